ftdi_rx_st_fifo: RTL and testbench

- Elastic Avalon-ST byte buffer between the FTDI read-side streaming bridge (upstream, produces bytes drained from the FT245 FIFO) and the Qsys bytes-to-packets sink (downstream).
- Absorbs back-pressure bursts from the packet decoder, so the FTDI device's RXF_n/RD_n cycle is not stalled byte-by-byte.
- Reports fill level, almost-full and a high-water mark for debug and PIO readback.

---
 rtl/ftdi_rx_st_fifo_pkg.sv | 20 ++
 rtl/ftdi_fifo_ram.sv | 27 ++
 rtl/ftdi_rx_st_fifo.sv | 104 ++++++++++
 tb/tb_ftdi_rx_st_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_rx_st_fifo_pkg.sv
// Shared constants and types for the FTDI receive-side Avalon-ST byte buffer.
package ftdi_rx_st_fifo_pkg;

    localparam int AVST_BYTE_W     = 8;
    localparam int FIFO_DEPTH_LOG2 = 4;
    localparam int FIFO_AFULL_TH   = 12;

    // Occupancy update selected by {push, pop}
    typedef enum logic [1:0] {
        LVL_HOLD = 2'b00,
        LVL_DEC  = 2'b01,
        LVL_INC  = 2'b10,
        LVL_BOTH = 2'b11
    } lvl_op_e;

    function automatic lvl_op_e lvl_op(input logic push, input logic pop);
        return lvl_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/ftdi_fifo_ram.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module ftdi_fifo_ram
    import ftdi_rx_st_fifo_pkg::*;
#(
    parameter int DATA_W = AVST_BYTE_W,
    parameter int ADDR_W = FIFO_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ftdi_rx_st_fifo.sv
// Elastic Avalon-ST byte FIFO between the FTDI read bridge and the packet sink,
// with first-word-fall-through output, level, almost-full and high-water-mark.
module ftdi_rx_st_fifo
    import ftdi_rx_st_fifo_pkg::*;
#(
    parameter int DATA_W     = AVST_BYTE_W,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
    parameter int AFULL_TH   = FIFO_AFULL_TH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iCLR,
    input  logic                  iSNK_VALID,
    output logic                  oSNK_READY,
    input  logic [DATA_W-1:0]     iSNK_DATA,
    output logic                  oSRC_VALID,
    input  logic                  iSRC_READY,
    output logic [DATA_W-1:0]     oSRC_DATA,
    output logic [DEPTH_LOG2:0]   oLEVEL,
    output logic                  oALMOST_FULL,
    output logic [DEPTH_LOG2:0]   oHWM
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_TH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] level;
    logic [PW-1:0] level_next;
    logic [PW-1:0] hwm;
    logic          almost_full;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    lvl_op_e       op;

    // Wrap-bit pointer comparison; both flags depend on registered pointers only
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

    assign push = iSNK_VALID & ~full  & ~iCLR;
    assign pop  = iSRC_READY & ~empty & ~iCLR;
    assign op   = lvl_op(push, pop);

    // Next occupancy from the handshake pair
    always_comb begin
        level_next = level;
        case (op)
            LVL_INC:  level_next = level + PW'(1);
            LVL_DEC:  level_next = level - PW'(1);
            LVL_HOLD: level_next = level;
            LVL_BOTH: level_next = level;
            default:  level_next = level;
        endcase
    end

    // Pointers, level counter, almost-full and high-water mark; flush wins over handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            hwm         <= '0;
        end else if (iCLR) begin
            rd_ptr      <= wr_ptr;
            level       <= '0;
            almost_full <= 1'b0;
            hwm         <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level       <= level_next;
            almost_full <= (level_next >= AFULL_LVL);
            hwm         <= (level_next > hwm) ? level_next : hwm;
        end
    end

    ftdi_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[PW-2:0]),
        .wdata (iSNK_DATA),
        .raddr (rd_ptr[PW-2:0]),
        .rdata (oSRC_DATA)
    );

    assign oSNK_READY   = ~full;
    assign oSRC_VALID   = ~empty;
    assign oLEVEL       = level;
    assign oALMOST_FULL = almost_full;
    assign oHWM         = hwm;

endmodule

// File: tb/tb_ftdi_rx_st_fifo.sv
// Self-checking bench: vector table plus directed sequences, with a queue scoreboard per DUT.
module tb_ftdi_rx_st_fifo;

    logic       clk = 1'b0;
    logic       rst, clr;
    logic       sv, srdy, sr, ov, af;
    logic [7:0] sd, od;
    logic [4:0] lvl, hwm;
    logic       sv2, srdy2, sr2, ov2, af2;
    logic [7:0] sd2, od2;
    logic [2:0] lvl2, hwm2;

    int errors = 0;
    int checks = 0;
    int rx1 = 0;
    int rx2 = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int hwm1_m = 0;
    int hwm2_m = 0;

    always #5 clk = ~clk;

    ftdi_rx_st_fifo dut (
        .clk(clk), .rst(rst), .iCLR(clr),
        .iSNK_VALID(sv), .oSNK_READY(sr), .iSNK_DATA(sd),
        .oSRC_VALID(ov), .iSRC_READY(srdy), .oSRC_DATA(od),
        .oLEVEL(lvl), .oALMOST_FULL(af), .oHWM(hwm)
    );

    ftdi_rx_st_fifo #(.DATA_W(8), .DEPTH_LOG2(2), .AFULL_TH(3)) dut2 (
        .clk(clk), .rst(rst), .iCLR(clr),
        .iSNK_VALID(sv2), .oSNK_READY(sr2), .iSNK_DATA(sd2),
        .oSRC_VALID(ov2), .iSRC_READY(srdy2), .oSRC_DATA(od2),
        .oLEVEL(lvl2), .oALMOST_FULL(af2), .oHWM(hwm2)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 16-entry instance
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            hwm1_m = 0;
        end else begin
            chk("lvl1", checks, 32'(lvl), q1.size());
            chk("rdy1", checks, 32'(sr), 32'(q1.size() < 16));
            chk("val1", checks, 32'(ov), 32'(q1.size() != 0));
            chk("af1",  checks, 32'(af), 32'(q1.size() >= 12));
            chk("hwm1", checks, 32'(hwm), hwm1_m);
            if (clr) begin
                q1.delete();
                hwm1_m = 0;
            end else begin
                if (ov && srdy && q1.size() != 0) begin
                    chk("data1", rx1, 32'(od), 32'(q1.pop_front()));
                    rx1++;
                end
                if (sv && sr) q1.push_back(sd);
                if (q1.size() > hwm1_m) hwm1_m = q1.size();
            end
        end
    end

    // Scoreboard for the 4-entry instance
    always @(negedge clk) begin
        if (rst) begin
            q2.delete();
            hwm2_m = 0;
        end else begin
            chk("lvl2", checks, 32'(lvl2), q2.size());
            chk("rdy2", checks, 32'(sr2), 32'(q2.size() < 4));
            chk("val2", checks, 32'(ov2), 32'(q2.size() != 0));
            chk("af2",  checks, 32'(af2), 32'(q2.size() >= 3));
            chk("hwm2", checks, 32'(hwm2), hwm2_m);
            if (clr) begin
                q2.delete();
                hwm2_m = 0;
            end else begin
                if (ov2 && srdy2 && q2.size() != 0) begin
                    chk("data2", rx2, 32'(od2), 32'(q2.pop_front()));
                    rx2++;
                end
                if (sv2 && sr2) q2.push_back(sd2);
                if (q2.size() > hwm2_m) hwm2_m = q2.size();
            end
        end
    end

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       srdy;
        logic       clr;
        logic       e_rdy;
        logic       e_val;
        logic [4:0] e_lvl;
        logic       e_af;
        logic [4:0] e_hwm;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int n1, n2, base1, base2, cyc;
        logic acc1, acc2;

        // Flush, 16 pushes against a stalled sink, then a 17th byte that must be refused
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0};
        for (int k = 1; k <= 16; k++)
            vecs[k] = '{1'b1, 8'(k - 1), 1'b0, 1'b0, (k < 16), 1'b1, 5'(k), (k >= 12), 5'(k)};
        vecs[17] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd16, 1'b1, 5'd16};

        rst = 1'b1; clr = 1'b0;
        sv = 1'b0; sd = 8'h00; srdy = 1'b0;
        sv2 = 1'b0; sd2 = 8'h00; srdy2 = 1'b0;
        #12 rst = 1'b0;
        tick();

        chk("rst_rdy", 0, 32'(sr), 32'd1);
        chk("rst_val", 0, 32'(ov), 32'd0);
        chk("rst_lvl", 0, 32'(lvl), 32'd0);
        chk("rst_hwm", 0, 32'(hwm), 32'd0);
        chk("rst_af",  0, 32'(af), 32'd0);

        sv = 1'b1; sd = 8'hA5;
        tick();
        sv = 1'b0;
        chk("first_val", 0, 32'(ov), 32'd1);
        chk("first_dat", 0, 32'(od), 32'hA5);
        chk("first_lvl", 0, 32'(lvl), 32'd1);
        srdy = 1'b1;
        tick();
        srdy = 1'b0;
        chk("first_pop", 0, 32'(ov), 32'd0);

        for (int i = 0; i < 18; i++) begin
            sv = vecs[i].vld; sd = vecs[i].data; srdy = vecs[i].srdy; clr = vecs[i].clr;
            tick();
            clr = 1'b0;
            chk("vec_rdy", i, 32'(sr), 32'(vecs[i].e_rdy));
            chk("vec_val", i, 32'(ov), 32'(vecs[i].e_val));
            chk("vec_lvl", i, 32'(lvl), 32'(vecs[i].e_lvl));
            chk("vec_af",  i, 32'(af), 32'(vecs[i].e_af));
            chk("vec_hwm", i, 32'(hwm), 32'(vecs[i].e_hwm));
        end

        // Full with a pop: push stays refused, head byte is 0x00
        srdy = 1'b1;
        chk("fullpop_rdy", 0, 32'(sr), 32'd0);
        chk("fullpop_dat", 0, 32'(od), 32'h00);
        tick();
        sv = 1'b0; srdy = 1'b0;
        chk("fullpop_lvl", 0, 32'(lvl), 32'd15);
        chk("fullpop_rdy1", 0, 32'(sr), 32'd1);
        base1 = rx1;
        srdy = 1'b1;
        repeat (15) tick();
        srdy = 1'b0;
        chk("drain_cnt", 0, rx1 - base1, 32'd15);
        chk("drain_lvl", 0, 32'(lvl), 32'd0);
        chk("drain_hwm", 0, 32'(hwm), 32'd16);

        // Streaming with random back-pressure on both depths
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n1 = 0; n2 = 0; cyc = 0;
        base1 = rx1; base2 = rx2;
        while ((rx1 - base1 < 1000 || rx2 - base2 < 1000) && cyc < 20000) begin
            sv = (n1 < 1000); sd = 8'(n1); srdy = 1'($urandom_range(0, 1));
            sv2 = (n2 < 1000); sd2 = 8'(n2); srdy2 = 1'($urandom_range(0, 1));
            acc1 = sv & sr;
            acc2 = sv2 & sr2;
            tick();
            if (acc1) n1++;
            if (acc2) n2++;
            cyc++;
        end
        sv = 1'b0; srdy = 1'b0; sv2 = 1'b0; srdy2 = 1'b0;
        chk("stream_rx1", 0, rx1 - base1, 32'd1000);
        chk("stream_rx2", 0, rx2 - base2, 32'd1000);
        chk("stream_hwm2", 0, 32'(hwm2 <= 3'd4), 32'd1);

        // Flush with a byte offered in the same cycle
        sv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sd = 8'(8'h40 + i);
            tick();
        end
        chk("pre_clr_lvl", 0, 32'(lvl), 32'd5);
        clr = 1'b1; sd = 8'h77;
        tick();
        clr = 1'b0; sv = 1'b0;
        chk("clr_lvl", 0, 32'(lvl), 32'd0);
        chk("clr_val", 0, 32'(ov), 32'd0);
        chk("clr_hwm", 0, 32'(hwm), 32'd0);
        chk("clr_af",  0, 32'(af), 32'd0);
        sv = 1'b1; sd = 8'h11;
        tick();
        sv = 1'b0;
        chk("post_clr_dat", 0, 32'(od), 32'h11);
        chk("post_clr_lvl", 0, 32'(lvl), 32'd1);
        srdy = 1'b1;
        tick();
        srdy = 1'b0;

        // Asynchronous reset in the middle of a transfer
        sv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sd = 8'(8'h80 + i);
            tick();
        end
        sv = 1'b0;
        chk("pre_rst_lvl", 0, 32'(lvl), 32'd8);
        #2 rst = 1'b1;
        #1;
        chk("arst_rdy", 0, 32'(sr), 32'd1);
        chk("arst_val", 0, 32'(ov), 32'd0);
        chk("arst_lvl", 0, 32'(lvl), 32'd0);
        chk("arst_hwm", 0, 32'(hwm), 32'd0);
        chk("arst_af",  0, 32'(af), 32'd0);
        #4 rst = 1'b0;
        tick();
        sv = 1'b1; sd = 8'h3C;
        tick();
        sv = 1'b0;
        chk("post_rst_dat", 0, 32'(od), 32'h3C);
        chk("post_rst_lvl", 0, 32'(lvl), 32'd1);
        srdy = 1'b1;
        tick();
        srdy = 1'b0;
        chk("post_rst_empty", 0, 32'(ov), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
